// File: rtl/ff_pkg.sv
// Shared definitions for the pseudo-Mersenne field multiplier:
// FSM state encoding, op encoding, secp256k1 defaults and parameter helpers.
package ff_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MUL   = 3'd1,
    ST_FOLD1 = 3'd2,
    ST_FOLD2 = 3'd3,
    ST_FINAL = 3'd4,
    ST_OUT   = 3'd5
  } ff_state_e;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_SQR = 1'b1;

  // secp256k1: P = 2^256 - 0x1000003D1
  localparam int           FF_W = 256;
  localparam logic [255:0] FF_C = 256'h1000003D1;

  // Widest field the helpers below can describe.
  localparam int FF_PMAX = 1024;

  // P = 2^w - c, returned zero-extended to FF_PMAX bits.
  function automatic logic [FF_PMAX-1:0] ff_prime(input int w, input logic [FF_PMAX-1:0] c);
    logic [FF_PMAX-1:0] one;
    one = FF_PMAX'(1);
    return (one << w) - c;
  endfunction

  // Number of significant bits in v (0 for v == 0).
  function automatic int ff_bit_len(input logic [FF_PMAX-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < FF_PMAX; i++) begin
      if (v[i]) n = i + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/ff_reduce_pm.sv
// Reduction datapath for P = 2^W - C. The fold stage selects its source:
// the 2W-bit product in FOLD1, the previous fold result in FOLD2. The final
// conditional subtract works on the registered fold result. The caller
// registers the outputs, so this block is purely combinational.
module ff_reduce_pm
  import ff_pkg::*;
#(
  parameter int         W = FF_W,
  parameter logic [W-1:0] C = W'(FF_C)
) (
  input  ff_state_e                                     stage,
  input  logic [2*W-1:0]                                acc,
  input  logic [W+ff_bit_len(FF_PMAX'(C))+1-1:0]        t,
  output logic [W+ff_bit_len(FF_PMAX'(C))+1-1:0]        fold_out,
  output logic [W-1:0]                                  r_out
);

  localparam int             CW  = ff_bit_len(FF_PMAX'(C));
  localparam int             TW  = W + CW + 1;
  localparam logic [CW-1:0]  C_N = C[CW-1:0];
  localparam logic [W-1:0]   P   = W'(ff_prime(W, FF_PMAX'(C)));

  logic [2*W-1:0] fold_in;
  logic           t_ge_p;

  // Fold: hi * C + lo, since 2^W == C (mod P). Values stay below 2^TW.
  always_comb begin
    fold_in = acc;
    if (stage != ST_FOLD1) fold_in = {{(2*W-TW){1'b0}}, t};
    fold_out = TW'(fold_in[2*W-1:W]) * TW'(C_N) + TW'(fold_in[W-1:0]);
  end

  // Final correction: after two folds t < 2P, so one subtract lands in [0, P).
  // t - P < P < 2^W, hence the low W bits of the difference are exact.
  always_comb begin
    t_ge_p = (t >= {{(TW-W){1'b0}}, P});
    r_out  = t_ge_p ? (t[W-1:0] - P) : t[W-1:0];
  end

endmodule

// File: rtl/ff_mul_pm.sv
// Digit-serial pseudo-Mersenne field multiplier: tx_c = a*b mod (2^W - C),
// or a*a in square mode. One operation in flight at a time.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. rx_ready is high only in IDLE; tx_valid is high only in
// OUT, where tx_c/tx_tag are held stable until tx_ready. rx_ready depends
// on the registered state only, never on tx_ready.
module ff_mul_pm
  import ff_pkg::*;
#(
  parameter int           W     = FF_W,
  parameter int           D     = 32,
  parameter logic [W-1:0] C     = W'(FF_C),
  parameter int           TAG_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             rx_valid,
  output logic             rx_ready,
  input  logic             rx_op,
  input  logic [W-1:0]     rx_a,
  input  logic [W-1:0]     rx_b,
  input  logic [TAG_W-1:0] rx_tag,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [W-1:0]     tx_c,
  output logic [TAG_W-1:0] tx_tag,
  output logic [2:0]       dbg_state
);

  localparam int NDIG  = W / D;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int CW    = ff_bit_len(FF_PMAX'(C));
  localparam int TW    = W + CW + 1;

  ff_state_e          state, state_n;
  logic [W-1:0]       a_q, b_q;
  logic [TAG_W-1:0]   tag_q;
  logic [2*W-1:0]     acc;
  logic [CNT_W-1:0]   cnt;
  logic [TW-1:0]      t_q;

  logic [D-1:0]       digit;
  logic [W+D-1:0]     prod;
  logic [2*W-1:0]     pp;
  logic [TW-1:0]      fold_out;
  logic [W-1:0]       r_out;

  assign dbg_state = state;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_n;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_n  = state;
    rx_ready = 1'b0;
    tx_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        rx_ready = 1'b1;
        if (rx_valid) state_n = ST_MUL;
      end
      ST_MUL:   if (cnt == CNT_W'(NDIG - 1)) state_n = ST_FOLD1;
      ST_FOLD1: state_n = ST_FOLD2;
      ST_FOLD2: state_n = ST_FINAL;
      ST_FINAL: state_n = ST_OUT;
      ST_OUT: begin
        tx_valid = 1'b1;
        if (tx_ready) state_n = ST_IDLE;
      end
      default:  state_n = ST_IDLE;
    endcase
  end

  // Partial product for the current digit of b, aligned to its weight.
  always_comb begin
    digit = b_q[cnt*D +: D];
    prod  = (W+D)'(a_q) * (W+D)'(digit);
    pp    = {{(W-D){1'b0}}, prod} << (cnt*D);
  end

  ff_reduce_pm #(
    .W (W),
    .C (C)
  ) u_reduce (
    .stage    (state),
    .acc      (acc),
    .t        (t_q),
    .fold_out (fold_out),
    .r_out    (r_out)
  );

  // Datapath registers: operand capture, accumulate, fold, final result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q    <= '0;
      b_q    <= '0;
      tag_q  <= '0;
      acc    <= '0;
      cnt    <= '0;
      t_q    <= '0;
      tx_c   <= '0;
      tx_tag <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rx_valid) begin
            a_q <= rx_a;
            case (rx_op)
              OP_MUL:  b_q <= rx_b;
              OP_SQR:  b_q <= rx_a;
              default: b_q <= rx_b;
            endcase
            tag_q <= rx_tag;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        ST_MUL: begin
          acc <= acc + pp;
          cnt <= cnt + CNT_W'(1);
        end
        ST_FOLD1, ST_FOLD2: t_q <= fold_out;
        ST_FINAL: begin
          tx_c   <= r_out;
          tx_tag <= tag_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ff_mul_pm.sv
// Bench for ff_mul_pm with secp256k1 defaults: directed corner cases,
// backpressure, mid-operation reset, then randomized traffic scored
// against a modular-arithmetic reference model.
module tb_ff_mul_pm;

  localparam int W     = 256;
  localparam int TAG_W = 8;
  localparam int N_RND = 1000;
  localparam logic [W-1:0] P_REF =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             rx_valid;
  logic             rx_ready;
  logic             rx_op;
  logic [W-1:0]     rx_a, rx_b;
  logic [TAG_W-1:0] rx_tag;
  logic             tx_valid;
  logic             tx_ready;
  logic [W-1:0]     tx_c;
  logic [TAG_W-1:0] tx_tag;
  logic [2:0]       dbg_state;

  int n_chk = 0;
  int n_err = 0;
  bit abort = 1'b0;

  logic [W-1:0]     exp_q[$];
  logic [TAG_W-1:0] exp_tag_q[$];

  ff_mul_pm dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rx_op     (rx_op),
    .rx_a      (rx_a),
    .rx_b      (rx_b),
    .rx_tag    (rx_tag),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_c      (tx_c),
    .tx_tag    (tx_tag),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] ref_mod_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] prod, modulus;
    prod    = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    modulus = {{W{1'b0}}, P_REF};
    return W'(prod % modulus);
  endfunction

  function automatic logic [W-1:0] rand_operand();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
    case ($urandom_range(0, 9))
      0:       v = P_REF - 1;
      1:       v = P_REF;
      2:       v = '1;
      3:       v = '0;
      4:       v = W'($urandom_range(0, 15));
      default: ;
    endcase
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  // Present one request at the negedge, hold until accepted.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic op, input logic [TAG_W-1:0] tag);
    int k;
    k = 0;
    while (!rx_ready && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (!rx_ready) begin
      check("rx_ready_wait", rx_ready, 1'b1);
      abort = 1'b1;
    end else begin
      rx_valid = 1'b1;
      rx_op    = op;
      rx_a     = a;
      rx_b     = b;
      rx_tag   = tag;
      @(negedge clk);
      rx_valid = 1'b0;
      rx_a     = $urandom;
      rx_b     = $urandom;
    end
  endtask

  // Wait for tx_valid (tx_ready low), report cycles waited, then accept it.
  task automatic get_result(output logic [W-1:0] c, output logic [TAG_W-1:0] tg, output int lat);
    lat = 0;
    while (!tx_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check("tx_valid_wait", tx_valid, 1'b1);
    c  = tx_c;
    tg = tx_tag;
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
  endtask

  task automatic directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic op, input logic [TAG_W-1:0] tag, input logic [W-1:0] exp);
    logic [W-1:0]     c;
    logic [TAG_W-1:0] tg;
    int               lat;
    send(a, b, op, tag);
    get_result(c, tg, lat);
    check({name, "_c"}, c, exp);
    check({name, "_tag"}, tg, tag);
  endtask

  // ---------------- stimulus + scoreboard ----------------
  initial begin
    logic [W-1:0]     c, c0, a, b, ex;
    logic [TAG_W-1:0] tg, tg0;
    logic             op;
    int               lat, n_hi, received, idle;

    reset_n  = 1'b0;
    rx_valid = 1'b0;
    rx_op    = 1'b0;
    rx_a     = '0;
    rx_b     = '0;
    rx_tag   = '0;
    tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_c", tx_c, '0);
    check("rst_tx_tag", tx_tag, '0);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_rx_ready", rx_ready, 1'b1);
    check("rst_tx_valid2", tx_valid, 1'b0);

    // Identity with exact latency.
    send(W'(1), W'(1), 1'b0, 8'h5A);
    get_result(c, tg, lat);
    check("id_latency", lat, 11);
    check("id_c", c, W'(1));
    check("id_tag", tg, 8'h5A);
    check("id_valid_drop", tx_valid, 1'b0);
    check("id_rx_ready", rx_ready, 1'b1);

    directed("max", P_REF - 1, P_REF - 1, 1'b0, 8'h11, W'(1));
    directed("unred", P_REF, W'(1), 1'b0, 8'h22, '0);
    a = '0;
    a[W-1] = 1'b1;
    directed("wrap", a, W'(2), 1'b0, 8'h33, W'(64'h1000003D1));
    directed("sqr", W'(3), '1, 1'b1, 8'h44, W'(9));
    directed("rand_dir", a - 5, P_REF - 3, 1'b0, 8'h55, ref_mod_mul(a - 5, P_REF - 3));

    // Backpressure: hold tx_ready low for 5 cycles after tx_valid rises.
    a = rand_operand();
    b = rand_operand();
    send(a, b, 1'b0, 8'hC3);
    lat = 0;
    while (!tx_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check("bp_valid", tx_valid, 1'b1);
    c0  = tx_c;
    tg0 = tx_tag;
    check("bp_c", c0, ref_mod_mul(a, b));
    check("bp_tag", tg0, 8'hC3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_c", tx_c, c0);
      check("bp_hold_tag", tx_tag, tg0);
      check("bp_hold_valid", tx_valid, 1'b1);
      check("bp_rx_ready_low", rx_ready, 1'b0);
    end
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    check("bp_valid_drop", tx_valid, 1'b0);
    check("bp_rx_ready_rise", rx_ready, 1'b1);

    // Reset in the middle of the digit loop.
    send(W'(5), W'(5), 1'b0, 8'h77);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    n_hi = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_valid) n_hi++;
    end
    check("mid_rst_no_valid", n_hi, 0);
    check("mid_rst_c", tx_c, '0);
    check("mid_rst_tag", tx_tag, '0);
    check("mid_rst_rx_ready", rx_ready, 1'b1);
    directed("after_rst", W'(7), W'(6), 1'b0, 8'h0F, W'(42));

    // Randomized traffic with random tx_ready.
    received = 0;
    fork
      begin
        for (int i = 0; i < N_RND && !abort; i++) begin
          a  = rand_operand();
          b  = rand_operand();
          op = 1'($urandom_range(0, 1));
          tg = 8'($urandom_range(0, 255));
          ex = (op == 1'b1) ? ref_mod_mul(a, a) : ref_mod_mul(a, b);
          exp_q.push_back(ex);
          exp_tag_q.push_back(tg);
          send(a, b, op, tg);
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
      end
      begin
        idle = 0;
        while (received < N_RND && !abort) begin
          @(negedge clk);
          tx_ready = ($urandom_range(0, 3) != 0);
          if (tx_valid && tx_ready) begin
            idle = 0;
            if (exp_q.size() == 0) begin
              check("rnd_unexpected", tx_valid, 1'b0);
              abort = 1'b1;
            end else begin
              check("rnd_c", tx_c, exp_q.pop_front());
              check("rnd_tag", tx_tag, exp_tag_q.pop_front());
              received++;
            end
          end else begin
            idle++;
            if (idle > 1000) abort = 1'b1;
          end
        end
        @(negedge clk);
        tx_ready = 1'b0;
      end
    join
    check("rnd_count", received, N_RND);

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
